// File: rtl/signal_select_scheduler_if.sv
// Output sample stream: captured sample plus its channel tag, valid/ready handshake.
interface signal_select_scheduler_if #(
  parameter int bitwidth = 16
);
  logic [bitwidth-1:0] data_out;
  logic [7:0]          channel_out;
  logic                data_valid;
  logic                data_ready;

  modport master (output data_out, output channel_out, output data_valid, input data_ready);
  modport slave  (input data_out, input channel_out, input data_valid, output data_ready);
endinterface

// File: rtl/signal_select_scheduler.sv
// Round-robin scheduler sharing one registered SignalSelect mux among the sources.
// Per-channel pending/overflow bookkeeping lives in a small per-channel cell.

module signal_select_scheduler_chan (
  input  logic clk,
  input  logic reset_n,
  input  logic i_en,
  input  logic i_avail,
  input  logic i_gnt,
  input  logic i_clr_ov,
  output logic o_pend,
  output logic o_ov
);
  logic r_pend, r_ov;

  // Pending: mask clears, new pulse beats grant-clear. Overflow: new event beats clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend <= 1'b0;
      r_ov   <= 1'b0;
    end else begin
      if (!i_en)        r_pend <= 1'b0;
      else if (i_avail) r_pend <= 1'b1;
      else if (i_gnt)   r_pend <= 1'b0;
      if (i_en & i_avail & r_pend & ~i_gnt) r_ov <= 1'b1;
      else if (i_clr_ov)                    r_ov <= 1'b0;
    end
  end

  assign o_pend = r_pend;
  assign o_ov   = r_ov;
endmodule

module signal_select_scheduler #(
  parameter int bitwidth = 16,
  parameter int channels = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [channels-1:0]    enable_mask,
  input  logic [channels-1:0]    available_in,
  output logic [7:0]             channel_select,
  input  logic [bitwidth-1:0]    mux_signal,
  signal_select_scheduler_if.master out_if,
  output logic [channels-1:0]    overflow,
  input  logic                   clear_overflow
);
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_OUTPUT  = 2'd3;

  logic [1:0]          r_state;
  logic [7:0]          r_last, r_sel, r_chan;
  logic [bitwidth-1:0] r_data;
  logic                r_valid;

  logic [channels-1:0] w_pend, w_req, w_hit, w_gnt;
  logic                w_arb, w_any;
  logic [7:0]          w_gidx;

  for (genvar i = 0; i < channels; i++) begin : g_ch
    signal_select_scheduler_chan u_ch (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_en     (enable_mask[i]),
      .i_avail  (available_in[i]),
      .i_gnt    (w_gnt[i]),
      .i_clr_ov (clear_overflow),
      .o_pend   (w_pend[i]),
      .o_ov     (overflow[i])
    );
  end

  // Masked channels never compete, even if their pending bit has not cleared yet.
  assign w_req = w_pend & enable_mask;
  // Arbitration runs when idle or on the edge that accepts the held sample.
  assign w_arb = (r_state == ST_IDLE) | ((r_state == ST_OUTPUT) & out_if.data_ready);
  assign w_gnt = w_arb ? w_hit : '0;

  // Round-robin pick: scan downward so the nearest index after r_last wins.
  always_comb begin
    w_any  = 1'b0;
    w_gidx = '0;
    w_hit  = '0;
    for (int k = channels; k >= 1; k--) begin
      if (w_req[(int'(r_last) + k) % channels]) begin
        w_any  = 1'b1;
        w_gidx = 8'((int'(r_last) + k) % channels);
        w_hit  = '0;
        w_hit[(int'(r_last) + k) % channels] = 1'b1;
      end
    end
  end

  // Grant / wait-for-mux / capture / hold-until-accepted sequence.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_last  <= 8'(channels - 1);
      r_sel   <= '0;
      r_chan  <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (w_arb) begin
      r_valid <= 1'b0;
      if (w_any) begin
        r_sel   <= w_gidx;
        r_chan  <= w_gidx;
        r_last  <= w_gidx;
        r_state <= ST_WAIT;
      end else begin
        r_state <= ST_IDLE;
      end
    end else begin
      case (r_state)
        ST_WAIT:    r_state <= ST_CAPTURE;
        ST_CAPTURE: begin
          r_data  <= mux_signal;
          r_valid <= 1'b1;
          r_state <= ST_OUTPUT;
        end
        default: ;
      endcase
    end
  end

  assign channel_select     = r_sel;
  assign out_if.data_out    = r_data;
  assign out_if.channel_out = r_chan;
  assign out_if.data_valid  = r_valid;
endmodule

// File: tb/tb_signal_select_scheduler.sv
// Scoreboard bench: a transaction-level model predicts grants, pushes expected
// samples into a queue; a negedge monitor compares everything the DUT presents.
module tb_signal_select_scheduler;
  localparam int BW = 16;
  localparam int CH = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [CH-1:0] enable_mask, available_in, overflow;
  logic [7:0]    channel_select;
  logic [BW-1:0] mux_signal;
  logic          clear_overflow;
  logic [BW-1:0] src [CH];

  signal_select_scheduler_if #(.bitwidth(BW)) sif ();

  signal_select_scheduler #(.bitwidth(BW), .channels(CH)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable_mask    (enable_mask),
    .available_in   (available_in),
    .channel_select (channel_select),
    .mux_signal     (mux_signal),
    .out_if         (sif),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  always #5 clk = ~clk;

  // Registered multiplexer: one cycle from select to output.
  always @(posedge clk) mux_signal <= src[channel_select[2:0]];

  int n_chk = 0;
  int n_err = 0;
  bit done = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int ch; logic [BW-1:0] data; } exp_t;
  exp_t sbq[$];

  bit [CH-1:0] m_pend, m_ov;
  int          m_last;
  bit [7:0]    m_sel;
  bit          m_busy, m_vld;
  int          m_gcyc, cyc = 0;

  // Server is either free or busy with one sample; the sample becomes visible
  // two edges after its grant and stays until an accepting edge.
  always @(posedge clk or negedge reset_n) begin : model
    bit          free;
    int          g;
    bit [CH-1:0] gv, req;
    if (!reset_n) begin
      m_pend = '0; m_ov = '0; m_last = CH - 1; m_sel = '0;
      m_busy = 0; m_vld = 0; m_gcyc = 0;
      sbq.delete();
    end else begin
      cyc++;
      free = !m_busy || (m_vld && sif.data_ready);
      if (m_vld && sif.data_ready) m_busy = 0;
      req = m_pend & enable_mask;
      g = -1;
      if (free)
        for (int k = 1; k <= CH; k++)
          if (g < 0 && req[(m_last + k) % CH]) g = (m_last + k) % CH;
      gv = '0;
      if (g >= 0) begin
        gv[g] = 1'b1;
        m_last = g;
        m_sel = 8'(g);
        m_busy = 1;
        m_gcyc = cyc;
        sbq.push_back('{g, src[g]});
      end
      for (int i = 0; i < CH; i++) begin
        if (available_in[i] && enable_mask[i] && m_pend[i] && !gv[i]) m_ov[i] = 1'b1;
        else if (clear_overflow) m_ov[i] = 1'b0;
        if (!enable_mask[i])      m_pend[i] = 1'b0;
        else if (available_in[i]) m_pend[i] = 1'b1;
        else if (gv[i])           m_pend[i] = 1'b0;
      end
      m_vld = m_busy && (cyc >= m_gcyc + 2);
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (reset_n && !done) begin
      chk("valid", 32'(sif.data_valid), 32'(m_vld));
      chk("channel_select", 32'(channel_select), 32'(m_sel));
      chk("overflow", 32'(overflow), 32'(m_ov));
      if (sif.data_valid) begin
        if (sbq.size() == 0) begin
          chk("spurious_valid", 32'(sif.data_valid), 32'd0);
        end else begin
          chk("channel_out", 32'(sif.channel_out), 32'(sbq[0].ch));
          chk("data_out", 32'(sif.data_out), 32'(sbq[0].data));
          if (sif.data_ready) void'(sbq.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [CH-1:0] m);
    available_in = m;
    tick();
    available_in = '0;
  endtask

  initial begin
    enable_mask = '1; available_in = '0; clear_overflow = 1'b0; sif.data_ready = 1'b0;
    for (int i = 0; i < CH; i++) src[i] = 16'($urandom);
    src[5] = 16'h1234;
    repeat (3) tick();
    chk("rst_valid", 32'(sif.data_valid), 32'd0);
    chk("rst_data", 32'(sif.data_out), 32'd0);
    chk("rst_chan", 32'(sif.channel_out), 32'd0);
    chk("rst_sel", 32'(channel_select), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    reset_n = 1'b1;
    tick();

    // single pulse on ch5
    sif.data_ready = 1'b1;
    pulse(8'h20);
    repeat (6) tick();

    // 0,3,7 together, then 7 and 0 (wraps to 0 first)
    pulse(8'h89);
    repeat (12) tick();
    pulse(8'h81);
    repeat (9) tick();

    // backpressure: ch2 held, ch4 waits
    sif.data_ready = 1'b0;
    pulse(8'h04);
    pulse(8'h10);
    repeat (8) tick();
    sif.data_ready = 1'b1;
    repeat (8) tick();

    // overflow on ch1 while ch0 holds the output
    sif.data_ready = 1'b0;
    pulse(8'h01);
    pulse(8'h02);
    tick();
    pulse(8'h02);
    repeat (3) tick();
    clear_overflow = 1'b1; tick(); clear_overflow = 1'b0;
    tick();
    clear_overflow = 1'b1; available_in = 8'h02; tick();
    clear_overflow = 1'b0; available_in = '0;
    repeat (2) tick();
    sif.data_ready = 1'b1;
    repeat (10) tick();
    clear_overflow = 1'b1; tick(); clear_overflow = 1'b0;

    // masking on ch6
    enable_mask = 8'hBF;
    pulse(8'h40);
    repeat (5) tick();
    enable_mask = '1;
    sif.data_ready = 1'b0;
    pulse(8'h01);
    pulse(8'h40);
    enable_mask = 8'hBF;
    tick();
    sif.data_ready = 1'b1;
    repeat (8) tick();
    enable_mask = '1;

    // reset while in WAIT
    pulse(8'h08);
    tick();
    reset_n = 1'b0;
    #1;
    chk("rstwait_valid", 32'(sif.data_valid), 32'd0);
    chk("rstwait_sel", 32'(channel_select), 32'd0);
    tick();
    reset_n = 1'b1;
    repeat (8) tick();

    // randomized traffic
    for (int c = 0; c < 800; c++) begin
      available_in   = CH'($urandom & $urandom);
      sif.data_ready = ($urandom % 4) != 0;
      clear_overflow = ($urandom % 16) == 0;
      if ($urandom % 32 == 0) enable_mask = CH'($urandom) | 8'h0F;
      tick();
    end
    available_in = '0; clear_overflow = 1'b0; enable_mask = '1; sif.data_ready = 1'b1;
    repeat (40) tick();
    chk("drain_empty", 32'(sbq.size()), 32'd0);

    done = 1;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/signal_select_scheduler.md
# signal_select_scheduler

Round-robin scheduler that shares one registered `SignalSelect` multiplexer among up to `channels` data sources. It latches per-channel "sample available" pulses as pending requests and grants one channel at a time by driving the multiplexer's `channel_select`. It captures the multiplexer output after its register latency and presents the sample with its channel tag on a valid/ready stream toward the FIFO/pipe interface.

## Interface
- `bitwidth`, 16, sample width; must match the multiplexer's `bitwidth`
- `channels`, 8, number of sources; 1..8, must match the multiplexer's `channels`
- `clk`  in  1  system clock; all logic on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `enable_mask`  in  `channels`  per-channel enable; 0 masks the channel and clears its pending bit
- `available_in`  in  `channels`  per-channel single-cycle "new sample" pulses from the sources
- `channel_select`  out  8  registered select driven to the multiplexer
- `mux_signal`  in  `bitwidth`  multiplexer `signal_out`
- `data_out`  out  `bitwidth`  captured sample
- `channel_out`  out  8  channel index of `data_out`
- `data_valid`  out  1  output stream valid
- `data_ready`  in  1  output stream ready from the consumer
- `overflow`  out  `channels`  sticky flag per channel: a new pulse arrived while the previous request was still pending
- `clear_overflow`  in  1  synchronous clear of all `overflow` bits

## Operation
- Pending register `pend[channels]`, per edge, per channel i:
  - set by `available_in[i] & enable_mask[i]`
  - cleared when i is granted
  - set wins over grant-clear in the same cycle
  - forced 0 when `enable_mask[i]`=0
- Overflow: `overflow[i]` is set when `available_in[i] & enable_mask[i] & pend[i]` and i is not granted this cycle. Set wins over `clear_overflow` in the same cycle.
- Arbitration is round-robin:
  - search order starts at `last+1` and wraps modulo `channels`
  - `last` updates to the granted index on every grant
  - reset value of `last` is `channels-1`, so channel 0 has first priority
- FSM states:
  - IDLE: if any `pend` is set, grant: `channel_select`<=g, clear `pend[g]`, `channel_out`<=g, go to WAIT. Otherwise stay.
  - WAIT: one cycle while the multiplexer registers. Go to CAPTURE.
  - CAPTURE: `data_out`<=`mux_signal`, `data_valid`<=1, go to OUTPUT.
  - OUTPUT: hold `data_out`, `channel_out` and `data_valid` stable until `data_valid & data_ready`. On the accepting edge, `data_valid`<=0 and arbitration runs exactly as in IDLE: grant and go to WAIT if any `pend` is set, otherwise go to IDLE.
- `channel_select` holds its last granted value between grants. It never selects a masked or out-of-range channel.
- Disabling a granted channel mid-transaction does not abort the transaction. The captured sample is still delivered.

## Timing
- Reset values: `channel_select`=0, `data_out`=0, `channel_out`=0, `data_valid`=0, `overflow`=0, `pend`=0, FSM=IDLE, `last`=`channels-1`.
- Latency: a pulse sampled at edge E0 sets `pend` at E0, gives a grant at E1 (if IDLE) and WAIT at E2. CAPTURE occurs at E3, so `data_valid` is high after E3. The pulse-to-valid latency is 3 cycles.
- The capture edge is 2 edges after the grant edge, which matches the multiplexer's 1-cycle registered output.
- Throughput with `data_ready` held at 1: one sample per 3 cycles (grant, wait, capture/accept+grant overlap).
- `data_ready` may be high before `data_valid`. No combinational path runs from `data_ready` to any output.
- An asserted `reset_n` mid-transaction immediately returns all state to reset values. A sample in flight is dropped and no partial output appears.
- A pulse on a channel in the same cycle it is granted leaves `pend` set. That channel is served again after the others, per round-robin order, and no overflow is flagged.

## Test plan
- Reset, then a single pulse on channel 5 with `mux_signal` modelled as a registered mux where ch5=0x1234 and `data_ready`=1 -> `channel_select`=5 one cycle after pend. `data_valid`=1 with `data_out`=0x1234 and `channel_out`=5 exactly 3 cycles after the pulse. `data_valid` drops the next cycle.
- Simultaneous pulses on channels 0, 3 and 7, with `data_ready`=1 -> outputs in order 0, 3, 7, spaced 3 cycles apart. Then pulses on 7 and 0 -> order 0, 7, because `last`=7 wraps to 0.
- Backpressure: `data_ready`=0 for 10 cycles with a pulse on ch2 and then ch4 -> ch2 sample held stable for all 10 cycles. After ready rises, ch4 is granted on the accept edge and its valid follows 2 cycles later.
- Overflow: two pulses on ch1 while `data_ready`=0 and ch1 is still pending -> `overflow[1]`=1 and it stays set. `clear_overflow` pulsed alone -> 0. `clear_overflow` in the same cycle as a new overflow event -> stays 1.
- Masking: pulse on ch6 with `enable_mask[6]`=0 -> no grant, no overflow. Set pending on ch6, then clear the mask before the grant -> pend cleared, no output.
- `reset_n` asserted during WAIT -> `data_valid`=0 and `channel_select`=0 immediately. No sample emitted after release until a new pulse arrives.
